// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit buffer and frame launcher between the APB register block and
// uart_core. Software pushes words into a DEPTH-entry FIFO. A small FSM pops
// one word at a time, pulses start_tx_o for one cycle and waits for
// tx_done_i before it launches the next frame.
//
// Optional feature macro: UART_TX_FIFO_THRESH_EN (adds thresh_i / thresh_irq_o)
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   wr_en_i          push request
//   wr_data_i        word to push
//   flush_i          discard every queued word (an in-flight frame continues)
//   clr_overflow_i   clear the sticky overflow flag
//   full_o, empty_o  registered occupancy flags
//   level_o          registered occupancy, 0..DEPTH
//   overflow_o       sticky: push attempted while full
//   busy_o           queue not empty or frame in flight
//   tx_data_o        word under transmission, held from launch until done
//   start_tx_o       one-cycle launch pulse per frame
//   tx_done_i        frame-complete strobe from uart_core
//   thresh_i         low-water threshold            (macro only)
//   thresh_irq_o     registered level_o <= thresh_i (macro only)
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     flush_i,
  input  logic                     clr_overflow_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     busy_o,
  output logic [DATA_W-1:0]        tx_data_o,
  output logic                     start_tx_o,
  input  logic                     tx_done_i
`ifdef UART_TX_FIFO_THRESH_EN
  ,
  input  logic [$clog2(DEPTH):0]   thresh_i,
  output logic                     thresh_irq_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [AW:0]       wr_ptr_s;
  logic [AW:0]       rd_ptr_s;
  logic [AW:0]       level_r;
  logic [AW:0]       level_s;
  logic              full_r;
  logic              full_s;
  logic              empty_r;
  logic              empty_s;
  logic              overflow_r;
  logic              overflow_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] tx_data_r;
  state_t            state_r;
  state_t            state_s;
  logic              start_tx_s;
  logic              busy_s;

  // Qualify push and pop; flush suppresses both so the pointer move below is exact.
  always_comb begin
    push_s = wr_en_i && !full_r && !flush_i;
    pop_s  = (state_r == ST_IDLE) && !empty_r && !flush_i;
  end

  // Next pointer values and the occupancy flags derived from them.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (flush_i) begin
      // Write pointer cannot move during a flush, so aligning read to it empties the queue.
      rd_ptr_s = wr_ptr_r;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
    end
    level_s = wr_ptr_s - rd_ptr_s;
    full_s  = (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
    empty_s = (wr_ptr_s == rd_ptr_s);
  end

  // Sticky overflow: a rejected push while full wins over a same-cycle clear.
  always_comb begin
    if (wr_en_i && full_r && !flush_i) begin
      overflow_s = 1'b1;
    end else if (clr_overflow_i) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Pointer, flag and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      level_r    <= {(AW+1){1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      level_r    <= level_s;
      full_r     <= full_s;
      empty_r    <= empty_s;
      overflow_r <= overflow_s;
    end
  end

  // Storage array write port; contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_i;
    end
  end

  // Launch data register: loaded on pop and held through START and WAIT (flush leaves it alone).
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      tx_data_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; tx_done_i only matters in ST_WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded purely from registered state.
  always_comb begin
    start_tx_s = (state_r == ST_START);
    busy_s     = (state_r != ST_IDLE) || !empty_r;
  end

  assign full_o     = full_r;
  assign empty_o    = empty_r;
  assign level_o    = level_r;
  assign overflow_o = overflow_r;
  assign tx_data_o  = tx_data_r;
  assign start_tx_o = start_tx_s;
  assign busy_o     = busy_s;

`ifdef UART_TX_FIFO_THRESH_EN
  logic thresh_irq_r;

  // Low-water flag, one cycle behind level_o; reset value matches an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_irq_r <= 1'b1;
    end else begin
      thresh_irq_r <= (level_r <= thresh_i);
    end
  end

  assign thresh_irq_o = thresh_irq_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo (DEPTH=16, DATA_W=32). A queue-based
// reference model tracks queued words, the frame in flight and the sticky
// flags; every cycle the DUT outputs are compared against it. Directed steps
// follow the scenarios of interest, then a randomized phase runs.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          busy;
  logic [DW-1:0] tx_data;
  logic          start_tx;
  logic          tx_done;
  logic [AW:0]   thresh_v;
`ifdef UART_TX_FIFO_THRESH_EN
  logic          thresh_irq;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en),
    .wr_data_i      (wr_data),
    .flush_i        (flush),
    .clr_overflow_i (clr_ovf),
    .full_o         (full),
    .empty_o        (empty),
    .level_o        (level),
    .overflow_o     (overflow),
    .busy_o         (busy),
    .tx_data_o      (tx_data),
    .start_tx_o     (start_tx),
    .tx_done_i      (tx_done)
`ifdef UART_TX_FIFO_THRESH_EN
    ,
    .thresh_i       (thresh_v),
    .thresh_irq_o   (thresh_irq)
`endif
  );

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_active;   // a frame has been launched and not yet completed
  int            m_age;      // cycles since the launching pop
  logic [DW-1:0] m_tx;
  bit            m_ovf;
  bit            m_irq;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit wr, input logic [DW-1:0] d,
                            input bit fl, input bit clr, input bit done);
    int sz;
    bit full_pre;
    bit do_pop;
    if (r) begin
      q.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_tx     = '0;
      m_ovf    = 1'b0;
      m_irq    = 1'b1;
      return;
    end
    sz       = q.size();
    full_pre = (sz == DEPTH);
    do_pop   = !m_active && (sz > 0) && !fl;
    m_irq    = (sz <= int'(thresh_v));
    // a done strobe only completes a frame after its launch-pulse cycle
    if (m_active && m_age >= 1 && done) m_active = 1'b0;
    else if (m_active && m_age < 2) m_age++;
    if (do_pop) begin
      m_tx     = q.pop_front();
      m_active = 1'b1;
      m_age    = 0;
    end
    if (wr && !fl && full_pre) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (wr && !fl && !full_pre) q.push_back(d);
    if (fl) q.delete();
  endtask

  task automatic check_all();
    chk("level",    32'(level),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("busy",     32'(busy),     32'(m_active || q.size() > 0));
    chk("start_tx", 32'(start_tx), 32'(m_active && m_age == 0));
    chk("tx_data",  tx_data,       m_tx);
`ifdef UART_TX_FIFO_THRESH_EN
    chk("thresh_irq", 32'(thresh_irq), 32'(m_irq));
`endif
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit fl,
                      input bit clr, input bit done);
    wr_en   = wr;
    wr_data = d;
    flush   = fl;
    clr_ovf = clr;
    tx_done = done;
    @(posedge clk);
    model_edge(rst, wr, d, fl, clr, done);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] saved;

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
    tx_done  = 1'b0;
    thresh_v = 5'd2;
    q.delete();
    m_active = 1'b0; m_age = 0; m_tx = '0; m_ovf = 1'b0; m_irq = 1'b1;

    // reset state
    idle(2);
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_data",  tx_data,    32'd0);

    // single word: launch pulse two edges after the push
    step(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    chk("single_no_early_start", 32'(start_tx), 32'd0);
    idle(1);
    chk("single_start", 32'(start_tx), 32'd1);
    chk("single_data",  tx_data,       32'h41);
    idle(5);
    chk("single_no_repeat", 32'(start_tx), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("single_busy_fall", 32'(busy), 32'd0);
    idle(2);

    // burst of 18 pushes while the first frame stalls in WAIT
    for (int i = 1; i <= 18; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    chk("burst_level_full", 32'(level),    32'd16);
    chk("burst_overflow",   32'(overflow), 32'd1);
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("drain_order", tx_data, 32'(j + 2));
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // five queued behind the in-flight frame, then push and pop together
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("pushpop_level", 32'(level), 32'd5);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // 40 push+pop pairs wrap the pointers several times
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    // flush with 6 queued and a frame in WAIT
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_level", 32'(level), 32'd6);
    saved = tx_data;
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_data",  tx_data,    saved);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("flush_no_start", 32'(start_tx), 32'd0);
    chk("flush_idle",     32'(busy),     32'd0);

    // flush+push while full: no overflow; clear+overflow together: overflow wins
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("full_flag", 32'(full), 32'd1);
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    chk("flush_push_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    chk("set_beats_clear", 32'(overflow), 32'd1);

    // low-water threshold at 2: fill to 4, drain to 2
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    idle(1);
`ifdef UART_TX_FIFO_THRESH_EN
    chk("thresh_low_at4", 32'(thresh_irq), 32'd0);
`endif
    for (int j = 0; j < 2; j++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("drain_level2", 32'(level), 32'd2);
`ifdef UART_TX_FIFO_THRESH_EN
    chk("thresh_high_at2", 32'(thresh_irq), 32'd1);
`endif

    // reset mid-frame discards everything without waiting for done
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midreset_level", 32'(level), 32'd0);
    chk("midreset_busy",  32'(busy),  32'd0);
    chk("midreset_data",  tx_data,    32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) thresh_v = 5'($urandom_range(0, DEPTH));
      rst = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
